// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the multiply issue controller.
// Holds the FSM encoding and the {valid, tag} in-flight pipeline entry.
package fp_mul_pkg;

    localparam int FP_W    = 32;
    localparam int TAG_MAX = 16;

    typedef enum logic [1:0] {
        ST_WARM  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // The tag field is sized for the widest supported tag; narrower tags use the low bits.
    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
    } pipe_entry_t;

    function automatic pipe_entry_t pipe_bubble();
        return '{valid: 1'b0, tag: '0};
    endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// First-word-fall-through result FIFO; head entry is visible combinationally.
// Pointers wrap naturally because DEPTH is a power of two.
module fp_result_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_wr,
    input  logic [WIDTH-1:0]       i_wdata,
    input  logic                   i_rd,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_do_rd = i_rd && !o_empty;
    assign w_do_wr = i_wr && (!o_full || w_do_rd);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fp_mul_issue_ctrl.sv
// Issue/collect controller for a fixed-latency FP multiplier with credit-protected result FIFO.
// Optional FP_MUL_STATS_EN adds 32-bit issued/done handshake counters.
module fp_mul_issue_ctrl
    import fp_mul_pkg::*;
#(
    parameter int LATENCY    = 6,
    parameter int FIFO_DEPTH = 8,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_a,
    input  logic [FP_W-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    input  logic             flush,
    output logic             flush_done,
    output logic [FP_W-1:0]  mul_a,
    output logic [FP_W-1:0]  mul_b,
    output logic             mul_ce,
    input  logic [FP_W-1:0]  mul_result
`ifdef FP_MUL_STATS_EN
    ,
    output logic [31:0]      stat_issued,
    output logic [31:0]      stat_done
`endif
);

    localparam int CNT_W  = $clog2(LATENCY + FIFO_DEPTH + 1);
    localparam int WCNT_W = $clog2(LATENCY);
    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(LATENCY - 1);

    state_e              r_state;
    logic [WCNT_W-1:0]   r_warm_cnt;
    logic [CNT_W-1:0]    r_inflight;
    pipe_entry_t         r_pipe [LATENCY];
    logic [FP_W-1:0]     r_mul_a;
    logic [FP_W-1:0]     r_mul_b;
    logic                r_mul_ce;
    logic                r_flush_done;

    logic [TAG_MAX-1:0]      w_tag_ext;
    logic [CNT_W-1:0]        w_outstanding;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_wr;
    logic                    w_out_fire;
    logic [FCNT_W-1:0]       w_fifo_count;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [FP_W+TAG_W-1:0]   w_fifo_rdata;

    always_comb begin
        w_tag_ext            = '0;
        w_tag_ext[TAG_W-1:0] = in_tag;
    end

    // Everything accepted but not yet handed downstream must fit in the FIFO.
    assign w_outstanding = r_inflight + CNT_W'(w_fifo_count);
    assign w_in_ready    = (r_state == ST_RUN) && !flush
                           && (w_outstanding < CNT_W'(FIFO_DEPTH));
    assign w_accept      = in_valid && w_in_ready;
    assign w_wr          = r_pipe[LATENCY-1].valid;
    assign w_out_fire    = !w_fifo_empty && out_ready;

    assign in_ready   = w_in_ready;
    assign out_valid  = !w_fifo_empty;
    assign out_result = w_fifo_rdata[FP_W+TAG_W-1:TAG_W];
    assign out_tag    = w_fifo_rdata[TAG_W-1:0];
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign mul_ce     = r_mul_ce;
    assign flush_done = r_flush_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_WARM;
            r_warm_cnt   <= '0;
            r_mul_ce     <= 1'b0;
            r_flush_done <= 1'b0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                ST_WARM: begin
                    if (r_warm_cnt == WARM_LAST) begin
                        r_state  <= ST_RUN;
                        r_mul_ce <= 1'b1;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + WCNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        r_state <= ST_DRAIN;
                    end else if (w_accept) begin
                        r_mul_a <= in_a;
                        r_mul_b <= in_b;
                    end
                end
                ST_DRAIN: begin
                    if (r_inflight == '0 && w_fifo_empty) begin
                        r_flush_done <= 1'b1;
                        r_state      <= ST_RUN;
                    end
                end
                default: r_state <= ST_WARM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) r_pipe[i] <= pipe_bubble();
        end else begin
            r_pipe[0] <= w_accept ? '{valid: 1'b1, tag: w_tag_ext} : pipe_bubble();
            for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_wr})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    fp_result_fifo #(
        .WIDTH (FP_W + TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_wr),
        .i_wdata ({mul_result, r_pipe[LATENCY-1].tag[TAG_W-1:0]}),
        .i_rd    (w_out_fire),
        .o_rdata (w_fifo_rdata),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // A write into a full FIFO would silently lose a product.
    assert property (@(posedge clk) disable iff (!rst) !(w_wr && w_fifo_full && !w_out_fire));

`ifdef FP_MUL_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_issued <= '0;
            r_stat_done   <= '0;
        end else begin
            if (w_accept)   r_stat_issued <= r_stat_issued + 32'd1;
            if (w_out_fire) r_stat_done   <= r_stat_done + 32'd1;
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_done   = r_stat_done;
`endif

endmodule

// File: tb/tb_fp_mul_issue_ctrl.sv
// Bench for fp_mul_issue_ctrl: fixed-latency multiplier model, queue-based reference
// of accepted operations, and a per-cycle compare process on the falling edge.
module tb_fp_mul_issue_ctrl;

    localparam int L  = 6;
    localparam int D  = 8;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_a = '0;
    logic [31:0]   in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_result;
    logic [TW-1:0] out_tag;
    logic          flush = 1'b0;
    logic          flush_done;
    logic [31:0]   mul_a;
    logic [31:0]   mul_b;
    logic          mul_ce;
    logic [31:0]   mul_result;
`ifdef FP_MUL_STATS_EN
    logic [31:0]   stat_issued;
    logic [31:0]   stat_done;
`endif

    always #5 clk = ~clk;

    fp_mul_issue_ctrl #(.LATENCY(L), .FIFO_DEPTH(D), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .flush      (flush),
        .flush_done (flush_done),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_ce     (mul_ce),
        .mul_result (mul_result)
`ifdef FP_MUL_STATS_EN
        ,
        .stat_issued(stat_issued),
        .stat_done  (stat_done)
`endif
    );

    // Exact single-precision product for operands whose significands have few set bits.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            e = e + 1;
            p = p >> 1;
        end
        return {s, e[7:0], p[45:23]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0] ex;
        logic [7:0] mh;
        ex = 8'(100 + $urandom_range(0, 50));
        mh = 8'($urandom);
        return {1'($urandom), ex, mh, 15'd0};
    endfunction

    // Multiplier: result of the registered operands appears L-1 edges later; ce low clears it.
    logic [31:0] mpipe [L-1];
    always @(posedge clk) begin
        if (!mul_ce) begin
            for (int i = 0; i < L-1; i++) mpipe[i] <= 32'd0;
        end else begin
            mpipe[0] <= fmul(mul_a, mul_b);
            for (int i = 1; i < L-1; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_result = mpipe[L-2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0]   res;
        logic [TW-1:0] tag;
        int            avail;
    } exp_t;

    exp_t q[$];
    int   mode      = 0;   // 0 warm-up, 1 running, 2 draining
    int   warm_seen = 0;
    bit   done_next = 1'b0;
    int   accepts   = 0;
    int   pops      = 0;
    int   fd_count  = 0;

    always @(negedge clk) begin
        bit exp_ov;
        bit exp_ir;
        bit exp_fd;
        bit drain_empty;
        if (!rst) begin
            check("rst_out_valid",  32'(out_valid), 32'd0);
            check("rst_in_ready",   32'(in_ready), 32'd0);
            check("rst_flush_done", 32'(flush_done), 32'd0);
            check("rst_mul_ce",     32'(mul_ce), 32'd0);
            check("rst_out_result", out_result, 32'd0);
            check("rst_mul_a",      mul_a, 32'd0);
            q.delete();
            mode      = 0;
            warm_seen = 0;
            done_next = 1'b0;
        end else begin
            exp_fd      = done_next;
            done_next   = 1'b0;
            exp_ov      = (q.size() > 0) && (q[0].avail <= cyc);
            exp_ir      = (mode == 1) && !flush && (q.size() < D);
            drain_empty = (q.size() == 0);
            check("out_valid",  32'(out_valid), 32'(exp_ov));
            check("in_ready",   32'(in_ready), 32'(exp_ir));
            check("mul_ce",     32'(mul_ce), 32'(mode != 0));
            check("flush_done", 32'(flush_done), 32'(exp_fd));
            if (exp_ov && out_valid) begin
                check("out_result", out_result, q[0].res);
                check("out_tag",    32'(out_tag), 32'(q[0].tag));
            end
            if (exp_ov && out_ready) begin
                void'(q.pop_front());
                pops++;
            end
            if (exp_ir && in_valid) begin
                q.push_back('{res: fmul(in_a, in_b), tag: in_tag, avail: cyc + L + 1});
                accepts++;
            end
            if (flush_done) fd_count++;
            case (mode)
                0: begin
                    warm_seen++;
                    if (warm_seen == L) mode = 1;
                end
                1: if (flush) mode = 2;
                default: if (drain_empty) begin
                    mode      = 1;
                    done_next = 1'b1;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t,
                        input int budget, output int acc_cyc);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        acc_cyc  = -1;
        for (int k = 0; k < budget; k++) begin
            #1;
            if (in_ready) begin
                acc_cyc = cyc;
                tick();
                break;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        out_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (q.size() == 0 && !out_valid) break;
            tick();
        end
        check(name, 32'(q.size()), 32'd0);
    endtask

    task automatic wait_run(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check(name, 32'(n), 32'(L));
    endtask

    initial begin
        int          c0;
        int          c1;
        int          acc;
        int          pops0;
        int          fd0;
        bit          have;
        logic [31:0] a;
        logic [31:0] b;
        logic [TW-1:0] t;

        check("pin_fmul_2x3",    fmul(32'h4000_0000, 32'h4040_0000), 32'h40C0_0000);
        check("pin_fmul_1p5xm2", fmul(32'h3FC0_0000, 32'hC000_0000), 32'hC040_0000);

        // Reset release and warm-up
        tick(); tick(); tick();
        rst = 1'b1;
        wait_run("warm_cycles");

        // Single operation, 2.0 * 3.0
        out_ready = 1'b1;
        send(32'h4000_0000, 32'h4040_0000, 4'd5, 10, c0);
        check("single_accepted", 32'(c0 >= 0), 32'd1);
        c1 = -1;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) begin
                c1 = cyc;
                break;
            end
            tick();
        end
        check("single_latency", 32'(c1 - c0), 32'd7);
        check("single_result",  out_result, 32'h40C0_0000);
        check("single_tag",     32'(out_tag), 32'd5);
        wait_empty("single_drained");

        // Backpressure: only FIFO_DEPTH ops may be outstanding
        out_ready = 1'b0;
        pops0     = pops;
        acc       = 0;
        have      = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!have) begin
                in_a   = rnd_fp();
                in_b   = rnd_fp();
                in_tag = TW'(k);
                have   = 1'b1;
            end
            in_valid = 1'b1;
            #1;
            if (in_ready) begin
                acc++;
                have = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        check("bp_accepted",  32'(acc), 32'd8);
        check("bp_ready_low", 32'(in_ready), 32'd0);
        check("bp_no_output", 32'(pops - pops0), 32'd0);
        wait_empty("bp_drained");
        check("bp_delivered", 32'(pops - pops0), 32'd8);
        send(rnd_fp(), rnd_fp(), 4'd9, 10, c0);
        check("bp_resumed", 32'(c0 >= 0), 32'd1);
        wait_empty("bp_resume_drained");

        // Streaming with random valid and ready
        acc  = 0;
        have = 1'b0;
        for (int k = 0; k < 6000 && acc < 100; k++) begin
            if (!have) begin
                a    = rnd_fp();
                b    = rnd_fp();
                t    = TW'($urandom);
                have = 1'b1;
            end
            in_a      = a;
            in_b      = b;
            in_tag    = t;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_valid && in_ready) begin
                acc++;
                have = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        check("stream_accepted", 32'(acc), 32'd100);
        wait_empty("stream_drained");

        // Flush with three operations in flight
        out_ready = 1'b1;
        fd0       = fd_count;
        pops0     = pops;
        for (int i = 0; i < 3; i++) send(rnd_fp(), rnd_fp(), TW'(i + 1), 10, c0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_a     = rnd_fp();
        in_b     = rnd_fp();
        #1;
        check("flush_blocks_ready", 32'(in_ready), 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        check("flush_done_pulses", 32'(fd_count - fd0), 32'd1);
        check("flush_drained",     32'(pops - pops0), 32'd3);
        check("flush_back_to_run", 32'(in_ready), 32'd1);

        // Reset two cycles after an acceptance discards the operation
        send(32'h4000_0000, 32'h4040_0000, 4'd3, 10, c0);
        tick();
        rst = 1'b0;
        tick(); tick();
        pops0 = pops;
        rst   = 1'b1;
        wait_run("rewarm_cycles");
        for (int k = 0; k < 10; k++) tick();
        check("rst_no_stale", 32'(pops - pops0), 32'd0);
        send(32'h3FC0_0000, 32'hC000_0000, 4'd7, 10, c0);
        wait_empty("post_rst_drained");
        check("post_rst_delivered", 32'(pops - pops0), 32'd1);

`ifdef FP_MUL_STATS_EN
        check("stat_done_vs_issued", stat_done, stat_issued);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
